// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command bytes for the LCD bus sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    LOAD_INIT,
    IDLE,
    SETUP,
    EHIGH,
    ELOW,
    WAIT
  } lcd_state_e;

  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_FSET_8B2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;

  // Clear and home need extra settle time on the panel.
  function automatic logic slow_cmd(
    input logic       rs,
    input logic [7:0] d
  );
    return !rs && (d == LCD_CLEAR || d == LCD_HOME);
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-up command table for the HD44780 in 8-bit, 2-line mode.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0] idx,
  output logic [7:0] data
);

  always_comb begin
    data = 8'h00;
    case (idx)
      3'd0, 3'd1, 3'd2: data = LCD_FSET_8B2L;
      3'd3:             data = LCD_DISP_ON;
      3'd4:             data = LCD_CLEAR;
      3'd5:             data = LCD_ENTRY_INC;
      default:          data = 8'h00;
    endcase
  end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit write-only bus sequencer paced by the E-rate tick.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int POWERUP_TICKS    = 4,
  parameter int CLEAR_WAIT_TICKS = 1,
  parameter int INIT_LEN         = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int CNT_MAX =
    (POWERUP_TICKS > CLEAR_WAIT_TICKS) ?
    POWERUP_TICKS : CLEAR_WAIT_TICKS;
  localparam int CW = $clog2(CNT_MAX + 1);

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          e_q, e_d;
  logic          done_q, done_d;
  logic          step;
  logic [7:0]    rom_data;
  logic          last_init;
  logic          pwr_hit;
  logic          wait_hit;
  logic          need_wait;

  lcd_init_rom u_rom (
    .idx  (idx_q),
    .data (rom_data)
  );

  assign last_init = int'(idx_q) >= INIT_LEN - 1;
  assign pwr_hit   = int'(cnt_q) >= POWERUP_TICKS - 1;
  assign wait_hit  = int'(cnt_q) >= CLEAR_WAIT_TICKS - 1;
  assign need_wait = slow_cmd(rs_q, data_q) &&
                     (CLEAR_WAIT_TICKS > 0);

  assign wr_ready  = (state_q == IDLE) && done_q;
  assign busy      = !wr_ready;
  assign init_done = done_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = e_q;
  assign lcd_data  = data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    data_d  = data_q;
    e_d     = e_q;
    done_d  = done_q;
    step    = 1'b0;
    unique case (state_q)
      PWRUP: begin
        if (tick_i) begin
          if (pwr_hit) begin
            state_d = LOAD_INIT;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD_INIT: begin
        rs_d    = 1'b0;
        data_d  = rom_data;
        state_d = SETUP;
      end
      IDLE: begin
        // An accept edge never consumes a tick.
        if (wr_valid && wr_ready) begin
          rs_d    = wr_rs;
          data_d  = wr_data;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick_i) begin
          state_d = EHIGH;
          e_d     = 1'b1;
        end
      end
      EHIGH: begin
        if (tick_i) begin
          state_d = ELOW;
          e_d     = 1'b0;
        end
      end
      ELOW: begin
        if (tick_i) begin
          if (need_wait) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            step = 1'b1;
          end
        end
      end
      WAIT: begin
        if (tick_i) begin
          if (wait_hit) begin
            cnt_d = '0;
            step  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = PWRUP;
    endcase
    if (step) begin
      if (!done_q && !last_init) begin
        idx_d   = idx_q + 3'd1;
        state_d = LOAD_INIT;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      e_q     <= e_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Randomized bench for the LCD sequencer against a tick-schedule model.
module tb_lcd_hd44780_ctrl;

  localparam int PWR  = 4;
  localparam int CWT  = 1;
  localparam int NINI = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_i = 1'b0;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       init_done;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  lcd_hd44780_ctrl #(
    .POWERUP_TICKS    (PWR),
    .CLEAR_WAIT_TICKS (CWT),
    .INIT_LEN         (NINI)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_i    (tick_i),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_rs     (wr_rs),
    .wr_data   (wr_data),
    .init_done (init_done),
    .busy      (busy),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data)
  );

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         rise;
  } ev_t;

  logic [7:0] init_bytes [NINI] =
    '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  ev_t exp_q [$];
  ev_t cur;
  int  tick_cnt   = 0;
  int  busy_until = 1 << 30;
  int  init_end   = 1 << 30;
  int  acc_cnt    = 0;
  int  phase      = 0;
  int  vectors    = 0;
  int  errors     = 0;
  bit  prev_e     = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    phase  = (phase + 1) % 4;
    tick_i = (phase == 0);
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int extra(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? CWT : 0;
  endfunction

  task automatic model_reset();
    int  t;
    ev_t e;
    tick_cnt = 0;
    exp_q.delete();
    t = PWR;
    for (int i = 0; i < NINI; i++) begin
      e.rs   = 1'b0;
      e.d    = init_bytes[i];
      e.rise = t + 1;
      exp_q.push_back(e);
      t += 3 + extra(1'b0, init_bytes[i]);
    end
    init_end   = t;
    busy_until = t;
  endtask

  // Bus-cycle schedule: each byte is setup, E high, E low ticks plus settle.
  always @(posedge clk) begin
    bit  acc;
    ev_t e;
    if (rst) begin
      model_reset();
    end else begin
      acc = wr_valid && (tick_cnt >= busy_until);
      if (tick_i) tick_cnt++;
      if (acc) begin
        e.rs   = wr_rs;
        e.d    = wr_data;
        e.rise = tick_cnt + 1;
        exp_q.push_back(e);
        busy_until = tick_cnt + 3 + extra(wr_rs, wr_data);
        acc_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_e = 1'b0;
    end else begin
      check("wr_ready", 32'(wr_ready), 32'(tick_cnt >= busy_until));
      check("init_done", 32'(init_done), 32'(tick_cnt >= init_end));
      check("busy", 32'(busy), 32'(tick_cnt < busy_until));
      check("lcd_rw", 32'(lcd_rw), 32'd0);
      if (lcd_e === 1'b1 && !prev_e) begin
        if (exp_q.size() == 0) begin
          check("e_spurious", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("rise_tick", 32'(tick_cnt), 32'(cur.rise));
          check("rise_data", 32'(lcd_data), 32'(cur.d));
          check("rise_rs", 32'(lcd_rs), 32'(cur.rs));
        end
      end else if (lcd_e === 1'b0 && prev_e) begin
        check("fall_tick", 32'(tick_cnt), 32'(cur.rise + 1));
        check("fall_data", 32'(lcd_data), 32'(cur.d));
        check("fall_rs", 32'(lcd_rs), 32'(cur.rs));
      end
      prev_e = (lcd_e === 1'b1);
    end
  end

  task automatic reset_check();
    check("rst_e", 32'(lcd_e), 32'd0);
    check("rst_data", 32'(lcd_data), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_rw", 32'(lcd_rw), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
  endtask

  task automatic send(
    input logic       rs,
    input logic [7:0] d,
    input bit         hold
  );
    int base;
    base     = acc_cnt;
    wr_rs    = rs;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int n = 0; n < 600 && acc_cnt == base; n++)
      @(negedge clk);
    if (acc_cnt == base) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tick_cnt < busy_until && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic rand_write();
    logic [7:0] d;
    logic       rs;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    if ($urandom_range(0, 3) == 0) begin
      wr_valid = 1'b1;
      wr_rs    = 1'($urandom);
      wr_data  = 8'($urandom);
      @(negedge clk);
      wr_valid = 1'b0;
    end
    rs = 1'($urandom);
    d  = 8'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      rs = 1'b0;
      d  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
    end
    send(rs, d, 1'($urandom));
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_rs    = 1'b0;
    wr_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset_check();
    rst = 1'b0;
    send(1'b1, 8'h55, 1'b0);
    send(1'b1, 8'h41, 1'b0);
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'h80, 1'b0);
    send(1'b1, 8'h61, 1'b1);
    send(1'b1, 8'h62, 1'b1);
    send(1'b1, 8'h63, 1'b0);
    wait_idle();
    for (int n = 0; n < 8 && tick_i !== 1'b1; n++) @(negedge clk);
    check("tick_align", 32'(tick_i), 32'd1);
    send(1'b1, 8'h7A, 1'b0);
    for (int i = 0; i < 30; i++) rand_write();
    send(1'b1, 8'($urandom), 1'b0);
    for (int n = 0; n < 40 && lcd_e !== 1'b1; n++) @(negedge clk);
    check("e_before_rst", 32'(lcd_e), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    reset_check();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) rand_write();
    wait_idle();
    repeat (12) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    check("e_final", 32'(lcd_e), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
